// File: rtl/doorlock_entry_ctrl.sv
// Door-lock password entry controller: collects a 4-digit keypad code, checks it
// against a programmable password, and drives door-open, alarm, and FND mask outputs.
module doorlock_entry_ctrl #(
  parameter logic [15:0] DEFAULT_PW  = 16'h1234,
  parameter int unsigned OPEN_CYCLES = 8,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned MAX_FAIL    = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] digit_mask,
  output logic        door_open,
  output logic        alarm,
  output logic [3:0]  fail_cnt
);

  localparam int unsigned TIMER_W = 32;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned FAIL_W  = 4;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_ENTER     = 4'hB;
  localparam logic [3:0] KEY_PROG      = 4'hC;

  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(4);
  localparam logic [TIMER_W-1:0] OPEN_LAST = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  FAIL_MAX  = FAIL_W'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_PROG    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          pw_q, pw_d;
  logic [15:0]          buf_q, buf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FAIL_W-1:0]    fail_q, fail_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [15:0]          mask_q, mask_d;
  logic                 door_q, door_d;
  logic                 alarm_q, alarm_d;

  logic                 is_digit;
  logic                 timer_done;
  logic [FAIL_W-1:0]    fail_inc;

  assign is_digit   = (key_code <= KEY_DIGIT_MAX);
  assign fail_inc   = fail_q + FAIL_W'(1);
  assign timer_done = ((state_q == S_OPEN)    && (timer_q == OPEN_LAST)) ||
                      ((state_q == S_LOCKOUT) && (timer_q == LOCK_LAST));

  // Next-state, buffer, password and failure-count logic
  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;

    case (state_q)
      S_IDLE, S_ENTRY, S_PROG: begin
        if (key_valid) begin
          if (is_digit) begin
            if (cnt_q < CNT_FULL) begin
              case (cnt_q)
                CNT_W'(0): buf_d[15:12] = key_code;
                CNT_W'(1): buf_d[11:8]  = key_code;
                CNT_W'(2): buf_d[7:4]   = key_code;
                default:   buf_d[3:0]   = key_code;
              endcase
              cnt_d = cnt_q + CNT_W'(1);
              if (state_q != S_PROG) begin
                state_d = S_ENTRY;
              end
            end
          end else if (key_code == KEY_CLEAR) begin
            cnt_d = '0;
            buf_d = '0;
            if (state_q != S_PROG) begin
              state_d = S_IDLE;
            end
          end else if ((key_code == KEY_ENTER) && (cnt_q == CNT_FULL)) begin
            cnt_d = '0;
            buf_d = '0;
            if (state_q == S_PROG) begin
              pw_d    = buf_q;
              state_d = S_IDLE;
            end else if (buf_q == pw_q) begin
              fail_d  = '0;
              state_d = S_OPEN;
            end else if (fail_inc >= FAIL_MAX) begin
              fail_d  = FAIL_MAX;
              state_d = S_LOCKOUT;
            end else begin
              fail_d  = fail_inc;
              state_d = S_IDLE;
            end
          end else if ((key_code == KEY_PROG) && (state_q == S_PROG)) begin
            cnt_d   = '0;
            buf_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      // A key landing on the expiry edge is dropped: expiry wins
      S_OPEN: begin
        if (timer_done) begin
          state_d = S_IDLE;
        end else if (key_valid && (key_code == KEY_PROG)) begin
          cnt_d   = '0;
          buf_d   = '0;
          state_d = S_PROG;
        end
      end
      S_LOCKOUT: begin
        if (timer_done) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        buf_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Timer restarts on every state change and only runs in timed states
  always_comb begin
    timer_d = '0;
    if ((state_d == state_q) && ((state_q == S_OPEN) || (state_q == S_LOCKOUT))) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // Output values derived from the next state so they appear right after the sampling edge
  always_comb begin
    door_d  = (state_d == S_OPEN);
    alarm_d = (state_d == S_LOCKOUT);
    mask_d  = 16'hFFFF;
    case (state_d)
      S_OPEN:    mask_d = 16'hFFFF;
      S_LOCKOUT: mask_d = 16'h0000;
      default: begin
        case (cnt_d)
          CNT_W'(0): mask_d = 16'hFFFF;
          CNT_W'(1): mask_d = 16'h0FFF;
          CNT_W'(2): mask_d = 16'h00FF;
          CNT_W'(3): mask_d = 16'h000F;
          default:   mask_d = 16'h0000;
        endcase
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      pw_q    <= DEFAULT_PW;
      buf_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      mask_q  <= 16'hFFFF;
      door_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      mask_q  <= mask_d;
      door_q  <= door_d;
      alarm_q <= alarm_d;
    end
  end

  assign digit_mask = mask_q;
  assign door_open  = door_q;
  assign alarm      = alarm_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_doorlock_entry_ctrl.sv
// Bench for doorlock_entry_ctrl: directed key sequences, a queue-based reference
// model compared every cycle, and hand-computed spot values.
module tb_doorlock_entry_ctrl;

  localparam int MODEL_OPEN = 8;
  localparam int MODEL_LOCK = 16;
  localparam int MODEL_MAXF = 3;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] digit_mask;
  logic        door_open;
  logic        alarm;
  logic [3:0]  fail_cnt;

  int  n_total = 0;
  int  n_pass  = 0;
  bit  chk_on  = 1'b0;

  always #5 CLK = ~CLK;

  doorlock_entry_ctrl #(
    .DEFAULT_PW (16'h1234),
    .OPEN_CYCLES(8),
    .LOCK_CYCLES(16),
    .MAX_FAIL   (3)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digit_mask(digit_mask),
    .door_open (door_open),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt)
  );

  // Reference model: entered digits kept as a list, timers as remaining-cycle budgets
  typedef enum int {M_IDLE, M_ENTRY, M_OPEN, M_PROG, M_LOCK} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_dig[$];
  int    m_pw[4] = '{1, 2, 3, 4};
  int    m_fail = 0;
  int    m_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic m_reset();
    m_mode = M_IDLE;
    m_dig.delete();
    m_pw   = '{1, 2, 3, 4};
    m_fail = 0;
    m_left = 0;
  endtask

  task automatic m_step(input logic kv, input logic [3:0] kc);
    int  k;
    bit  same;
    k = int'(kc);
    if (m_mode == M_OPEN) begin
      m_left--;
      if (m_left == 0) m_mode = M_IDLE;
      else if (kv && k == 12) begin
        m_mode = M_PROG;
        m_dig.delete();
      end
    end else if (m_mode == M_LOCK) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = M_IDLE;
        m_fail = 0;
      end
    end else if (kv) begin
      if (k <= 9) begin
        if (m_dig.size() < 4) begin
          m_dig.push_back(k);
          if (m_mode != M_PROG) m_mode = M_ENTRY;
        end
      end else if (k == 10) begin
        m_dig.delete();
        if (m_mode != M_PROG) m_mode = M_IDLE;
      end else if (k == 11 && m_dig.size() == 4) begin
        if (m_mode == M_PROG) begin
          for (int i = 0; i < 4; i++) m_pw[i] = m_dig[i];
          m_mode = M_IDLE;
        end else begin
          same = 1'b1;
          for (int i = 0; i < 4; i++) if (m_dig[i] != m_pw[i]) same = 1'b0;
          if (same) begin
            m_mode = M_OPEN;
            m_left = MODEL_OPEN;
            m_fail = 0;
          end else begin
            m_fail++;
            if (m_fail == MODEL_MAXF) begin
              m_mode = M_LOCK;
              m_left = MODEL_LOCK;
            end else m_mode = M_IDLE;
          end
        end
        m_dig.delete();
      end else if (k == 12 && m_mode == M_PROG) begin
        m_dig.delete();
        m_mode = M_IDLE;
      end
    end
  endtask

  function automatic logic [15:0] m_mask();
    logic [15:0] m;
    if (m_mode == M_OPEN) return 16'hFFFF;
    if (m_mode == M_LOCK) return 16'h0000;
    m = 16'hFFFF;
    for (int i = 0; i < m_dig.size(); i++) m = m & ~(16'hF000 >> (4 * i));
    return m;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) m_reset();
    else m_step(key_valid, key_code);
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      check("model_mask",  32'(digit_mask), 32'(m_mask()));
      check("model_door",  32'(door_open),  32'(m_mode == M_OPEN));
      check("model_alarm", 32'(alarm),      32'(m_mode == M_LOCK));
      check("model_fail",  32'(fail_cnt),   32'(m_fail));
    end
  end

  task automatic press(input logic [3:0] c);
    @(negedge CLK);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge CLK);
    key_valid = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 0; i < 4; i++) begin
      press(c[15:12]);
      c = c << 4;
    end
    press(4'hB);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge CLK);
    check("rst_mask",  32'(digit_mask), 32'h0000FFFF);
    check("rst_door",  32'(door_open),  32'h0);
    check("rst_alarm", 32'(alarm),      32'h0);
    check("rst_fail",  32'(fail_cnt),   32'h0);
    RESET_N = 1'b1;
    chk_on  = 1'b1;

    // correct code and open window length
    press(4'h1); check("c1_mask1", 32'(digit_mask), 32'h0FFF);
    press(4'h2); check("c1_mask2", 32'(digit_mask), 32'h00FF);
    press(4'h3); check("c1_mask3", 32'(digit_mask), 32'h000F);
    press(4'h4); check("c1_mask4", 32'(digit_mask), 32'h0000);
    press(4'hB);
    check("c1_door", 32'(door_open), 32'h1);
    check("c1_mask_open", 32'(digit_mask), 32'hFFFF);
    n = 1;
    repeat (20) begin
      @(negedge CLK);
      if (door_open) n++;
    end
    check("c1_open_len", 32'(n), 32'd8);
    check("c1_closed", 32'(door_open), 32'h0);

    // entry edge cases
    press(4'h1); press(4'h2); press(4'hA);
    check("e_clear_mask", 32'(digit_mask), 32'hFFFF);
    press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'h9);
    check("e_fifth_mask", 32'(digit_mask), 32'h0000);
    press(4'hA); press(4'h1); press(4'h2); press(4'h3); press(4'hB);
    check("e_short_enter_mask", 32'(digit_mask), 32'h000F);
    check("e_short_enter_door", 32'(door_open), 32'h0);
    press(4'hA);

    // lockout after three failures
    enter4(16'h9999); check("l_fail1", 32'(fail_cnt), 32'd1);
    enter4(16'h9999); check("l_fail2", 32'(fail_cnt), 32'd2);
    enter4(16'h9999);
    check("l_alarm", 32'(alarm), 32'h1);
    check("l_mask", 32'(digit_mask), 32'h0000);
    check("l_fail3", 32'(fail_cnt), 32'd3);
    n = 1;
    for (int i = 0; i < 30; i++) begin
      key_valid = (i < 10);
      key_code  = 4'(i + 3);
      @(negedge CLK);
      if (alarm) n++;
    end
    key_valid = 1'b0;
    check("l_alarm_len", 32'(n), 32'd16);
    check("l_fail_clr", 32'(fail_cnt), 32'd0);
    check("l_mask_after", 32'(digit_mask), 32'hFFFF);

    // password change
    enter4(16'h1234); check("p_open", 32'(door_open), 32'h1);
    press(4'hC);
    check("p_door_drop", 32'(door_open), 32'h0);
    check("p_mask", 32'(digit_mask), 32'hFFFF);
    enter4(16'h5678); check("p_idle_door", 32'(door_open), 32'h0);
    enter4(16'h1234);
    check("p_old_fails", 32'(fail_cnt), 32'd1);
    check("p_old_door", 32'(door_open), 32'h0);
    enter4(16'h5678);
    check("p_new_opens", 32'(door_open), 32'h1);
    check("p_new_fail", 32'(fail_cnt), 32'd0);
    wait_cycles(12);

    // reset during OPEN reverts password
    enter4(16'h5678); check("r_open", 32'(door_open), 32'h1);
    @(negedge CLK); #2 RESET_N = 1'b0;
    #1;
    check("r_open_door", 32'(door_open), 32'h0);
    check("r_open_mask", 32'(digit_mask), 32'hFFFF);
    check("r_open_alarm", 32'(alarm), 32'h0);
    @(negedge CLK); RESET_N = 1'b1;
    enter4(16'h1234); check("r_default_pw", 32'(door_open), 32'h1);
    wait_cycles(12);

    // reset during PROG after two digits
    enter4(16'h1234); press(4'hC); press(4'h5); press(4'h6);
    check("r_prog_mask", 32'(digit_mask), 32'h00FF);
    #2 RESET_N = 1'b0;
    #1;
    check("r_prog_rst_mask", 32'(digit_mask), 32'hFFFF);
    check("r_prog_rst_door", 32'(door_open), 32'h0);
    @(negedge CLK); RESET_N = 1'b1;
    enter4(16'h1234); check("r_prog_reopen", 32'(door_open), 32'h1);
    wait_cycles(12);

    // key held for four cycles counts four presses
    @(negedge CLK);
    key_valid = 1'b1;
    key_code  = 4'h3;
    repeat (4) @(negedge CLK);
    key_valid = 1'b0;
    check("b_mask", 32'(digit_mask), 32'h0000);
    press(4'hB);
    check("b_fail", 32'(fail_cnt), 32'd1);
    check("b_door", 32'(door_open), 32'h0);
    wait_cycles(3);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/doorlock_entry_ctrl.md
# doorlock_entry_ctrl

Password-entry controller for the door-lock system, placed directly upstream of the 4-digit FND scanner. It takes debounced single-cycle keypad events, collects a 4-digit code, compares it against a stored password, and drives the door-open and alarm outputs. It also supports a password-change sequence and a lockout after repeated failures. Its `digit_mask` output feeds the FND scanner's 16-bit display input directly: nibble `4'h0` shows a "0" glyph, which is the masked-digit marker, and nibble `4'hF` shows blank.

## Interface
- `DEFAULT_PW`, `16'h1234`: password after reset, 4 BCD nibbles, first-entered digit in [15:12].
- `OPEN_CYCLES`, `8`: cycles `door_open` stays high after a correct code; valid range 1..2^32-1.
- `LOCK_CYCLES`, `16`: lockout duration in cycles; valid range 1..2^32-1.
- `MAX_FAIL`, `3`: consecutive failures that trigger lockout; valid range 1..15.
- `CLK`, input, 1: system clock, rising-edge.
- `RESET_N`, input, 1: asynchronous, active-low reset.
- `key_valid`, input, 1: one key press per cycle that is high.
- `key_code`, input, 4: `0..9` digit, `A` clear, `B` enter, `C` program; `D`/`E`/`F` ignored in all states.
- `digit_mask`, output, 16: FND display data.
- `door_open`, output, 1: lock actuator enable.
- `alarm`, output, 1: high during lockout.
- `fail_cnt`, output, 4: consecutive failed attempts.

## Operation
- **Reset state:** state IDLE, password register = `DEFAULT_PW`, digit buffer = 0, count = 0, `digit_mask` = `16'hFFFF`, `door_open` = 0, `alarm` = 0, `fail_cnt` = 0.
- **States:** IDLE, ENTRY, OPEN, PROG, LOCKOUT.
- **IDLE/ENTRY, digit key:**
  - count < 4: digit stored at position count (position 0 = [15:12]); count increments; state becomes ENTRY.
  - count = 4: key ignored.
- **IDLE/ENTRY, clear key:** count = 0, buffer = 0, state IDLE; `fail_cnt` unchanged.
- **IDLE/ENTRY, enter key with count < 4:** ignored; buffer kept.
- **IDLE/ENTRY, enter key with count = 4:**
  - Match: state OPEN, `fail_cnt` = 0.
  - Mismatch: `fail_cnt` + 1. If the new value equals `MAX_FAIL`, state LOCKOUT; otherwise state IDLE.
  - In all cases the buffer and count are cleared.
- **Program key outside OPEN:** ignored.
- **OPEN:**
  - `door_open` = 1; the timer counts `OPEN_CYCLES`, then state IDLE.
  - Digit, clear, and enter keys are ignored.
  - Program key: state PROG; `door_open` drops; timer cleared.
- **PROG:**
  - Digit and clear keys behave as in ENTRY, except clear stays in PROG with count = 0.
  - Enter with count = 4: password register = buffer; state IDLE.
  - Enter with count < 4: ignored.
  - Program key in PROG: abort to IDLE; old password kept.
- **LOCKOUT:** `alarm` = 1; all keys ignored; after `LOCK_CYCLES` cycles, state IDLE and `fail_cnt` = 0.
- **`digit_mask` by state:**
  - IDLE, ENTRY, PROG: nibble i = `4'h0` if i < count, else `4'hF`. Example: count = 1 gives `16'h0FFF`; count = 4 gives `16'h0000`.
  - OPEN: `16'hFFFF`.
  - LOCKOUT: `16'h0000`.
- **Registers:** all outputs are registers; nothing combinational drives a port.

## Timing
- A key is sampled on a rising edge where `key_valid` = 1. The resulting state and outputs are visible right after that same edge, i.e. one-cycle latency from input assertion.
- `key_valid` held high for N cycles counts as N presses. The upstream debouncer guarantees single-cycle pulses.
- **Door-open window:** `door_open` rises on the edge that samples the correct enter. It stays high for exactly `OPEN_CYCLES` cycles, then falls on the same edge that returns the state to IDLE.
- **Alarm window:** `alarm` is high for exactly `LOCK_CYCLES` cycles, starting on the edge that samples the failing enter.
- **Key on the timer-expiry edge:** a key arriving on the edge where the OPEN or LOCKOUT timer expires is ignored.
- **Timer:** 32-bit up-counter, cleared on every state entry; the compare is counter = parameter − 1.
- **`fail_cnt` width:** 4-bit saturating; it never exceeds `MAX_FAIL`.
- **Mid-operation reset:** assertion of `RESET_N` in any state forces the reset values immediately, asynchronously; a programmed password reverts to `DEFAULT_PW`.
- **Release:** deassertion is synchronous to `CLK` by the system reset synchronizer; the first key is accepted on the first edge after release.

## Test plan
All scenarios use the default parameters (`DEFAULT_PW` = `16'h1234`, `OPEN_CYCLES` = 8, `LOCK_CYCLES` = 16, `MAX_FAIL` = 3).

- **Correct code:** keys 1,2,3,4,B → `digit_mask` steps `0FFF`, `00FF`, `000F`, `0000`. Then `door_open` = 1 for exactly 8 cycles, `digit_mask` = `FFFF`, `fail_cnt` = 0, return to IDLE.
- **Entry edge cases:** keys 1,2,A → `digit_mask` `FFFF`. Then 5,6,7,8,9 → fifth digit ignored, mask `0000`. Then B with count 3 after clear → ignored.
- **Lockout:** three wrong codes 9,9,9,9,B → `fail_cnt` 1, 2, then `alarm` = 1 and mask `0000` for exactly 16 cycles. Keys during lockout have no effect; afterwards `fail_cnt` = 0.
- **Password change:** 1,2,3,4,B, then C within the open window → `door_open` = 0. Then 5,6,7,8,B → IDLE. Now 1,2,3,4,B fails (`fail_cnt` = 1), and 5,6,7,8,B opens.
- **Mid-operation reset:** pulse `RESET_N` low during OPEN and during PROG (after 2 digits) → outputs reset immediately, and 1,2,3,4,B opens again.
- **Back-to-back presses:** `key_valid` held high 4 cycles with `key_code` = 3 → count = 4, mask `0000`; 3,3,3,3,B gives a mismatch.
